// File: rtl/viterbi_decode_if.sv
// ---------------------------------------------------------------------------
// viterbi_decode_if
// Symbol-in / bit-out bundle for the (2,1,2) hard-decision Viterbi decoder.
//   code_sig[1:0]  received code symbol {b1,b0}
//   code_valid     qualifies code_sig, one symbol per clock when high
//   decode_sig     decoded information bit
//   decode_valid   one-cycle pulse per decoded bit
// master: symbol source / bit sink (e.g. testbench); slave: the decoder.
// ---------------------------------------------------------------------------
interface viterbi_decode_if;
    logic [1:0] code_sig;
    logic       code_valid;
    logic       decode_sig;
    logic       decode_valid;

    modport master (
        output code_sig,
        output code_valid,
        input  decode_sig,
        input  decode_valid
    );

    modport slave (
        input  code_sig,
        input  code_valid,
        output decode_sig,
        output decode_valid
    );
endinterface

// File: rtl/viterbi_decode.sv
// ---------------------------------------------------------------------------
// viterbi_decode
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (generators 7,5
// octal). Four-state add-compare-select with min-normalised saturating path
// metrics and a register-exchange survivor memory of TB_DEPTH bits per state.
// A decoded bit is emitted for every accepted symbol once TB_DEPTH-1 symbols
// have been seen since reset.
// Ports:
//   clk_sig    clock, rising edge
//   reset_sig  asynchronous active-low reset
//   bus        viterbi_decode_if.slave (code_sig/code_valid in,
//              decode_sig/decode_valid out)
// Parameters:
//   TB_DEPTH   survivor length in decisions (4..32)
//   PM_W       path-metric width in bits (4..8)
// ---------------------------------------------------------------------------
module viterbi_decode #(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned PM_W     = 5
) (
    input  logic              clk_sig,
    input  logic              reset_sig,
    viterbi_decode_if.slave   bus
);

    localparam int unsigned CW = $clog2(TB_DEPTH);
    localparam logic [CW-1:0]   FILL_MAX = CW'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0] PM_INIT  = {1'b1, {(PM_W-1){1'b0}}};

    logic [PM_W-1:0]     pm_q   [4];
    logic [PM_W-1:0]     pm_d   [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [CW-1:0]       fill_q, fill_d;
    logic                dec_q, dec_d;
    logic                dv_q, dv_d;

    // ACS results before normalisation
    logic [PM_W-1:0]     acc    [4];
    logic [TB_DEPTH-1:0] nsurv  [4];
    logic [1:0]          best;

    // Hamming distance between two 2-bit symbols
    function automatic logic [1:0] branch_metric(input logic [1:0] a,
                                                 input logic [1:0] b);
        return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    // PM + BM clamped to the all-ones metric
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                input logic [1:0]      bm);
        logic [PM_W:0] t;
        t = {1'b0, pm} + (PM_W+1)'(bm);
        return t[PM_W] ? '1 : t[PM_W-1:0];
    endfunction

    // Add-compare-select for each next state N={u,s1}; predecessors are
    // {s1,0} and {s1,1}, ties resolved toward s2=0.
    always_comb begin
        logic            u_b;
        logic            s1_b;
        logic [1:0]      p0;
        logic [1:0]      p1;
        logic [PM_W-1:0] sum0;
        logic [PM_W-1:0] sum1;
        u_b  = 1'b0;
        s1_b = 1'b0;
        p0   = '0;
        p1   = '0;
        sum0 = '0;
        sum1 = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            u_b  = n[1];
            s1_b = n[0];
            p0   = {s1_b, 1'b0};
            p1   = {s1_b, 1'b1};
            sum0 = sat_add(pm_q[p0],
                           branch_metric(bus.code_sig, {u_b ^ s1_b, u_b}));
            sum1 = sat_add(pm_q[p1],
                           branch_metric(bus.code_sig, {u_b ^ s1_b ^ 1'b1, u_b ^ 1'b1}));
            if (sum1 < sum0) begin
                acc[n]   = sum1;
                nsurv[n] = {surv_q[p1][TB_DEPTH-2:0], u_b};
            end else begin
                acc[n]   = sum0;
                nsurv[n] = {surv_q[p0][TB_DEPTH-2:0], u_b};
            end
        end
    end

    // Minimum-metric state, lowest index on ties
    always_comb begin
        best = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (acc[i] < acc[best]) begin
                best = 2'(i);
            end
        end
    end

    always_comb begin
        pm_d   = pm_q;
        surv_d = surv_q;
        fill_d = fill_q;
        dec_d  = dec_q;
        dv_d   = 1'b0;
        if (bus.code_valid) begin
            for (int unsigned n = 0; n < 4; n++) begin
                pm_d[n]   = acc[n] - acc[best];
                surv_d[n] = nsurv[n];
            end
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            // fill_q saturates at D-1, so equality means k >= D-1
            if (fill_q == FILL_MAX) begin
                dv_d  = 1'b1;
                dec_d = nsurv[best][TB_DEPTH-1];
            end
        end
    end

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            pm_q[0] <= '0;
            for (int unsigned n = 1; n < 4; n++) begin
                pm_q[n] <= PM_INIT;
            end
            for (int unsigned n = 0; n < 4; n++) begin
                surv_q[n] <= '0;
            end
            fill_q <= '0;
            dec_q  <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            pm_q   <= pm_d;
            surv_q <= surv_d;
            fill_q <= fill_d;
            dec_q  <= dec_d;
            dv_q   <= dv_d;
        end
    end

    assign bus.decode_sig   = dec_q;
    assign bus.decode_valid = dv_q;

endmodule

// File: tb/tb_viterbi_decode.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decode
// Scoreboard bench for viterbi_decode. The stimulus process encodes
// information bits with a golden (7,5) encoder, optionally injects channel
// errors and idle gaps, and queues the information bit each accepted symbol
// is expected to release (bit k-(D-1)). The monitor pops and compares on
// every decode_valid and checks that outputs are zero while in reset.
// ---------------------------------------------------------------------------
module tb_viterbi_decode;

    localparam int D = 16;

    logic clk_sig = 1'b0;
    logic reset_sig;

    viterbi_decode_if bus ();

    viterbi_decode #(
        .TB_DEPTH (D),
        .PM_W     (5)
    ) dut (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .bus       (bus)
    );

    always #5 clk_sig = ~clk_sig;

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         out_cnt = 0;
    bit         sb   [$];
    bit         info [$];
    logic [1:0] err  [$];
    bit         rnd_info [$];
    logic [1:0] rnd_err  [$];

    // Monitor: compare every decoded bit against the scoreboard
    always @(negedge clk_sig) begin
        if (reset_sig === 1'b0) begin
            n_cmp++;
            if (bus.decode_valid !== 1'b0 || bus.decode_sig !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: valid=%b bit=%b, required 0/0",
                         bus.decode_valid, bus.decode_sig);
            end
        end else if (bus.decode_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: decode_valid=1 at out %0d, required 0 (nothing pending)",
                         out_cnt);
            end else begin
                bit exp_b;
                exp_b = sb.pop_front();
                if (bus.decode_sig !== exp_b) begin
                    n_bad++;
                    $display("FAIL decoded_bit[%0d]: got %b, required %b",
                             out_cnt, bus.decode_sig, exp_b);
                end
            end
            out_cnt++;
        end else if (bus.decode_valid !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_x: decode_valid=%b, required 0 or 1", bus.decode_valid);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Entered and left at posedge+1
    task automatic send(input logic [1:0] s, input logic v);
        bus.code_sig   = s;
        bus.code_valid = v;
        @(posedge clk_sig);
        #1;
    endtask

    task automatic do_reset();
        reset_sig      = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_sig   = 2'b00;
        repeat (3) @(posedge clk_sig);
        #1;
        sb.delete();
        out_cnt   = 0;
        reset_sig = 1'b1;
    endtask

    // Encode the first n_use bits of info (with err masks), optionally with
    // random idle gaps; if check_end, drain and compare the output count.
    task automatic run_stream(input string name, input int gap_pct,
                              input int n_use, input bit check_end);
        logic s1, s2, u;
        logic [1:0] sym;
        int exp_cnt;
        int gaps;
        s1 = 1'b0;
        s2 = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < n_use; k++) begin
            u   = info[k];
            sym = {u ^ s1 ^ s2, u ^ s2};
            if (k < err.size()) sym = sym ^ err[k];
            gaps = 0;
            while (gaps < 8 && $urandom_range(99) < gap_pct) begin
                send(2'($urandom), 1'b0);
                gaps++;
            end
            if (k >= D - 1) begin
                sb.push_back(info[k - (D - 1)]);
                exp_cnt++;
            end
            send(sym, 1'b1);
            s2 = s1;
            s1 = u;
        end
        bus.code_valid = 1'b0;
        if (check_end) begin
            repeat (4) send(2'($urandom), 1'b0);
            n_cmp++;
            if (out_cnt != exp_cnt || sb.size() != 0) begin
                n_bad++;
                $display("FAIL %s_count: got %0d outputs (%0d pending), required %0d",
                         name, out_cnt, sb.size(), exp_cnt);
            end
        end
    endtask

    initial begin
        reset_sig      = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_sig   = 2'b00;

        // All-zero stream: first output after symbol 15, 25 zeros
        do_reset();
        info.delete(); err.delete();
        repeat (40) info.push_back(1'b0);
        run_stream("zeros", 0, 40, 1'b1);

        // Known message 1,0,1,1,0,0 then zeros
        do_reset();
        info.delete(); err.delete();
        info = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        repeat (20) info.push_back(1'b0);
        run_stream("known", 0, info.size(), 1'b1);

        // Same with symbol 2 corrupted (00 -> 10)
        do_reset();
        err.delete();
        repeat (info.size()) err.push_back(2'b00);
        err[2] = 2'b10;
        run_stream("known_err", 0, info.size(), 1'b1);

        // Random 200-bit stream with one flip every 8 symbols
        for (int i = 0; i < 200; i++) rnd_info.push_back(1'($urandom));
        repeat (20) rnd_info.push_back(1'b0);
        for (int i = 0; i < rnd_info.size(); i++)
            rnd_err.push_back((i % 8 == 7) ? (($urandom % 2) ? 2'b01 : 2'b10) : 2'b00);
        info = rnd_info;
        err  = rnd_err;
        do_reset();
        run_stream("random", 0, info.size(), 1'b1);

        // Same stream with random code_valid gaps
        do_reset();
        run_stream("random_gaps", 35, info.size(), 1'b1);

        // Reset pulse after symbol 20 discards everything in flight
        do_reset();
        run_stream("pre_reset", 0, 21, 1'b0);
        @(negedge clk_sig);
        #1;
        reset_sig = 1'b0;
        #1;
        n_cmp++;
        if (bus.decode_valid !== 1'b0 || bus.decode_sig !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_immediate: valid=%b bit=%b, required 0/0",
                     bus.decode_valid, bus.decode_sig);
        end
        sb.delete();
        @(negedge clk_sig);
        #1;
        reset_sig = 1'b1;
        @(posedge clk_sig);
        #1;
        out_cnt = 0;
        run_stream("after_reset", 0, 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
